// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Edges from the start sample to the result being visible in hi/lo.
    localparam int MD_LAT = 34;

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: IDLE -> CALC (WIDTH iterations) -> FIX.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    output logic load,
    output logic iter,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state and strobe decode.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        iter    = 1'b0;
        fix     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                iter  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix     = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counter and registered status flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic load, iter, fix;

    muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .load  (load),
        .iter  (iter),
        .fix   (fix),
        .busy  (busy),
        .done  (done)
    );

    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;        // multiplicand, or dividend shifted out MSB first
    logic [WIDTH-1:0]   b_q, b_d;        // multiplier shifted out LSB first, or divisor
    logic [WIDTH-1:0]   araw_q, araw_d;  // a as sampled, returned in hi on divide by zero
    logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or quotient in the low half
    logic [WIDTH-1:0]   rem_q, rem_d;    // always below the divisor, so WIDTH bits hold it
    logic               pneg_q, pneg_d;  // negate product/quotient at FIX
    logic               rneg_q, rneg_d;  // negate remainder at FIX
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sgn;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     part;   // shifted partial remainder
    logic [WIDTH+1:0]   diff;   // trial subtract with borrow in the MSB
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Operand latch, one shift-add / restoring-divide step, sign fix and HI/LO update.
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        araw_d = araw_q;
        acc_d  = acc_q;
        rem_d  = rem_q;
        pneg_d = pneg_q;
        rneg_d = rneg_q;
        dbz_d  = dbz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        sgn    = op_is_signed(op_e'(op));
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        part   = {rem_q, a_q[WIDTH-1]};
        diff   = {1'b0, part} - {2'b00, b_q};
        prod   = pneg_q ? -acc_q : acc_q;
        quo    = pneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = rneg_q ? -rem_q : rem_q;

        if (load) begin
            op_d   = op_e'(op);
            a_d    = (sgn && a[WIDTH-1]) ? -a : a;
            b_d    = (sgn && b[WIDTH-1]) ? -b : b;
            araw_d = a;
            acc_d  = '0;
            rem_d  = '0;
            pneg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = sgn && a[WIDTH-1];
            dbz_d  = (b == '0);
        end else if (!busy) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end

        if (iter) begin
            if (op_is_div(op_q)) begin
                a_d = {a_q[WIDTH-2:0], 1'b0};
                if (!diff[WIDTH+1]) begin
                    rem_d = diff[WIDTH-1:0];
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = part[WIDTH-1:0];
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
            end
        end

        if (fix) begin
            if (!op_is_div(op_q)) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end else if (dbz_q) begin
                hi_d = araw_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end
    end

    // Datapath and architectural HI/LO registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            araw_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            pneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            araw_q <= araw_d;
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            pneg_q <= pneg_d;
            rneg_q <= rneg_d;
            dbz_q  <= dbz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
